// File: rtl/sc_key_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sc_key_pulse_gen
//  Description : Key front end for the score/step up-counter. Synchronises a
//                raw active-low board key, debounces press and release, and
//                emits single-cycle active-low count pulses. An optional
//                auto-repeat keeps pulsing while the key stays held.
//  Ports       :
//    SC_KEYPULSE_CLOCK_50             in   system clock (50 MHz)
//    SC_KEYPULSE_RESET_InHigh         in   synchronous active-high reset
//    SC_KEYPULSE_key_InLow            in   raw asynchronous key, 0 = pressed
//    SC_KEYPULSE_repeatEnable_InHigh  in   1 = auto-repeat while held
//    SC_KEYPULSE_upcount_OutLow       out  registered, low 1 cycle per event
//    SC_KEYPULSE_pressed_OutHigh      out  registered debounced level, 1 = held
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_key_pulse_gen #(
    parameter int KEYPULSE_DEBOUNCE_CYCLES = 500000,
    parameter int KEYPULSE_REPEAT_DELAY    = 25000000,
    parameter int KEYPULSE_REPEAT_PERIOD   = 10000000,
    parameter int KEYPULSE_CNT_WIDTH       = 25
) (
    input  logic SC_KEYPULSE_CLOCK_50,
    input  logic SC_KEYPULSE_RESET_InHigh,
    input  logic SC_KEYPULSE_key_InLow,
    input  logic SC_KEYPULSE_repeatEnable_InHigh,
    output logic SC_KEYPULSE_upcount_OutLow,
    output logic SC_KEYPULSE_pressed_OutHigh
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    // Terminal counts: the counter sits at N-1 on the last cycle of an N-cycle wait.
    localparam logic [KEYPULSE_CNT_WIDTH-1:0] C_DEBOUNCE_LAST =
        KEYPULSE_CNT_WIDTH'(KEYPULSE_DEBOUNCE_CYCLES - 1);
    localparam logic [KEYPULSE_CNT_WIDTH-1:0] C_DELAY_LAST =
        KEYPULSE_CNT_WIDTH'(KEYPULSE_REPEAT_DELAY - 1);
    localparam logic [KEYPULSE_CNT_WIDTH-1:0] C_PERIOD_LAST =
        KEYPULSE_CNT_WIDTH'(KEYPULSE_REPEAT_PERIOD - 1);
    localparam logic [KEYPULSE_CNT_WIDTH-1:0] C_CNT_ONE =
        KEYPULSE_CNT_WIDTH'(1);

    logic                          r_sync1;
    logic                          r_sync2;
    logic [1:0]                    r_state;
    logic [KEYPULSE_CNT_WIDTH-1:0] r_cnt;
    logic                          r_rep_first;
    logic                          r_upcount;
    logic                          r_pressed;

    logic [1:0]                    w_state_next;
    logic [KEYPULSE_CNT_WIDTH-1:0] w_cnt_next;
    logic                          w_rep_first_next;
    logic                          w_upcount_next;
    logic                          w_pressed_next;
    logic [KEYPULSE_CNT_WIDTH-1:0] w_rep_last;

    // The first repeat waits the long delay; later repeats use the short period.
    assign w_rep_last = r_rep_first ? C_PERIOD_LAST : C_DELAY_LAST;

    // ------------------------------------------------------------------
    // State register, synchroniser, counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge SC_KEYPULSE_CLOCK_50) begin
        if (SC_KEYPULSE_RESET_InHigh) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rep_first <= 1'b0;
            r_upcount   <= 1'b1;
            r_pressed   <= 1'b0;
        end else begin
            r_sync1     <= SC_KEYPULSE_key_InLow;
            r_sync2     <= r_sync1;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rep_first <= w_rep_first_next;
            r_upcount   <= w_upcount_next;
            r_pressed   <= w_pressed_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and repeat-phase logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_rep_first_next = r_rep_first;
        case (r_state)
            ST_IDLE: begin
                if (!r_sync2) begin
                    w_state_next = ST_PRESS_DB;
                    w_cnt_next   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (r_sync2) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_DEBOUNCE_LAST) begin
                    w_state_next     = ST_HELD;
                    w_cnt_next       = '0;
                    w_rep_first_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end
            ST_HELD: begin
                if (r_sync2) begin
                    w_state_next = ST_RELEASE_DB;
                    w_cnt_next   = '0;
                end else if (!SC_KEYPULSE_repeatEnable_InHigh) begin
                    // Holding the repeat phase in reset means re-enabling starts with the long delay.
                    w_cnt_next       = '0;
                    w_rep_first_next = 1'b0;
                end else if (r_cnt == w_rep_last) begin
                    w_cnt_next       = '0;
                    w_rep_first_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end
            ST_RELEASE_DB: begin
                if (!r_sync2) begin
                    // Release was a bounce: resume holding with a fresh repeat phase.
                    w_state_next     = ST_HELD;
                    w_cnt_next       = '0;
                    w_rep_first_next = 1'b0;
                end else if (r_cnt == C_DEBOUNCE_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output next values (registered above so outputs are glitch-free)
    // ------------------------------------------------------------------
    always_comb begin
        w_upcount_next = 1'b1;
        w_pressed_next = r_pressed;
        case (r_state)
            ST_PRESS_DB: begin
                if (!r_sync2 && (r_cnt == C_DEBOUNCE_LAST)) begin
                    w_upcount_next = 1'b0;
                    w_pressed_next = 1'b1;
                end
            end
            ST_HELD: begin
                if (!r_sync2 && SC_KEYPULSE_repeatEnable_InHigh && (r_cnt == w_rep_last)) begin
                    w_upcount_next = 1'b0;
                end
            end
            ST_RELEASE_DB: begin
                if (r_sync2 && (r_cnt == C_DEBOUNCE_LAST)) begin
                    w_pressed_next = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign SC_KEYPULSE_upcount_OutLow  = r_upcount;
    assign SC_KEYPULSE_pressed_OutHigh = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_sc_key_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_key_pulse_gen
//  Description : Self-checking bench for sc_key_pulse_gen. A reference model
//                tracks the debounced level as "stable for DEB+1 samples" and
//                the repeat timer as "cycles since last restart".
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_key_pulse_gen;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 5;
    localparam int W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b1;
    logic en  = 1'b0;
    logic up;
    logic pressed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sc_key_pulse_gen #(
        .KEYPULSE_DEBOUNCE_CYCLES(DEB),
        .KEYPULSE_REPEAT_DELAY   (DLY),
        .KEYPULSE_REPEAT_PERIOD  (PER),
        .KEYPULSE_CNT_WIDTH      (W)
    ) dut (
        .SC_KEYPULSE_CLOCK_50           (clk),
        .SC_KEYPULSE_RESET_InHigh       (rst),
        .SC_KEYPULSE_key_InLow          (key),
        .SC_KEYPULSE_repeatEnable_InHigh(en),
        .SC_KEYPULSE_upcount_OutLow     (up),
        .SC_KEYPULSE_pressed_OutHigh    (pressed)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic key_pipe[$];     // two-sample delay of the raw key
    logic m_level = 1'b0;  // debounced "held" level
    int   m_run   = 0;     // consecutive samples disagreeing with m_level
    int   m_timer = 0;     // cycles since the repeat timer last restarted
    logic m_long  = 1'b1;  // next repeat gap is the long delay
    logic exp_up  = 1'b1;

    always @(posedge clk) begin
        logic s;
        cyc    = cyc + 1;
        exp_up = 1'b1;
        if (rst) begin
            key_pipe.delete();
            key_pipe.push_back(1'b1);
            key_pipe.push_back(1'b1);
            m_level = 1'b0;
            m_run   = 0;
            m_timer = 0;
            m_long  = 1'b1;
        end else begin
            key_pipe.push_back(key);
            s = key_pipe.pop_front();
            if (!m_level) begin
                if (s == 1'b0) begin
                    m_run = m_run + 1;
                    if (m_run == DEB + 1) begin
                        m_level = 1'b1;
                        m_run   = 0;
                        exp_up  = 1'b0;
                        m_timer = 0;
                        m_long  = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (s == 1'b1) begin
                    m_run = m_run + 1;
                    if (m_run == DEB + 1) begin
                        m_level = 1'b0;
                        m_run   = 0;
                    end
                end else if (m_run > 0) begin
                    m_run   = 0;
                    m_timer = 0;
                    m_long  = 1'b1;
                end else if (!en) begin
                    m_timer = 0;
                    m_long  = 1'b1;
                end else begin
                    m_timer = m_timer + 1;
                    if (m_timer == (m_long ? DLY : PER)) begin
                        exp_up  = 1'b0;
                        m_timer = 0;
                        m_long  = 1'b0;
                    end
                end
            end
        end
    end

    // Drive the key released long enough for any hold to be released.
    task automatic settle();
        key = 1'b1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int r, first_off, pulses;
        rst = 1'b1; key = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({up, pressed} !== 2'b10) begin
                errors++;
                $display("FAIL reset_hold cyc %0d up/pressed=%b%b expected 10", cyc, up, pressed);
            end
        end
        rst = 1'b0; r = cyc + 1; pulses = 0; first_off = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL reset_model cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
            if (up === 1'b0) begin
                pulses++;
                if (first_off < 0) first_off = cyc - r;
            end
        end
        checks++;
        if (pulses != 1 || first_off != 6) begin
            errors++;
            $display("FAIL reset_release_pulse count=%0d offset=%0d expected 1 at 6", pulses, first_off);
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_clean_press();
        int t0, rel, pulses, first_off, fall_off;
        en = 1'b0; key = 1'b0; t0 = cyc + 1; pulses = 0; first_off = -1; fall_off = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL clean_press cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
            if (up === 1'b0) begin
                pulses++;
                if (first_off < 0) first_off = cyc - t0;
            end
        end
        key = 1'b1; rel = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL clean_release cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
            if (up === 1'b0) pulses++;
            if (pressed === 1'b0 && fall_off < 0) fall_off = cyc - rel;
        end
        checks++;
        if (pulses != 1 || first_off != 6) begin
            errors++;
            $display("FAIL clean_pulse count=%0d offset=%0d expected 1 at 6", pulses, first_off);
        end
        checks++;
        if (fall_off != 6) begin
            errors++;
            $display("FAIL clean_pressed_fall offset=%0d expected 6", fall_off);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_press_bounce();
        int t0, pulses, first_off;
        en = 1'b0; t0 = cyc + 1; pulses = 0; first_off = -1;
        for (int i = 0; i < 20; i++) begin
            key = (i == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL press_bounce cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
            if (up === 1'b0) begin
                pulses++;
                if (first_off < 0) first_off = cyc - (t0 + 4);
            end
        end
        checks++;
        if (pulses != 1 || first_off != 6) begin
            errors++;
            $display("FAIL press_bounce_pulse count=%0d offset=%0d expected 1 at 6", pulses, first_off);
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_auto_repeat();
        int t0;
        int offs[$];
        int exp_offs[6];
        exp_offs = '{6, 16, 21, 26, 31, 36};
        en = 1'b1; t0 = cyc + 1;
        for (int i = 0; i < 50; i++) begin
            key = (i <= 38) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL auto_repeat cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
            if (up === 1'b0) offs.push_back(cyc - t0);
        end
        checks++;
        if (offs.size() != 6) begin
            errors++;
            $display("FAIL auto_repeat_count got %0d pulses expected 6", offs.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (offs[k] != exp_offs[k]) begin
                    errors++;
                    $display("FAIL auto_repeat_edge[%0d] got %0d expected %0d", k, offs[k], exp_offs[k]);
                end
            end
        end
        en = 1'b0;
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_release_bounce();
        int t0, h, first_off, drops;
        en = 1'b1; t0 = cyc + 1; h = t0 + 10; first_off = -1; drops = 0;
        for (int i = 0; i < 32; i++) begin
            key = (i == 10 || i == 11) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL release_bounce cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
            if (i >= 6 && pressed !== 1'b1) drops++;
            if (i >= 10 && up === 1'b0 && first_off < 0) first_off = cyc - h;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL release_bounce_pressed dropped %0d cycles expected 0", drops);
        end
        checks++;
        if (first_off != 14) begin
            errors++;
            $display("FAIL release_bounce_next_pulse offset=%0d expected 14", first_off);
        end
        en = 1'b0;
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_repeat();
        int t0, pre_pulses, post_off;
        en = 1'b1; key = 1'b0; t0 = cyc + 1; pre_pulses = 0; post_off = -1;
        for (int i = 0; i < 35; i++) begin
            rst = (i == 18);
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL reset_mid cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
            if (i == 18) begin
                checks++;
                if ({up, pressed} !== 2'b10) begin
                    errors++;
                    $display("FAIL reset_mid_outputs up/pressed=%b%b expected 10", up, pressed);
                end
            end
            if (up === 1'b0) begin
                if (i < 18) pre_pulses++;
                else if (post_off < 0) post_off = cyc - (t0 + 19);
            end
        end
        rst = 1'b0;
        checks++;
        if (pre_pulses != 2 || post_off != 6) begin
            errors++;
            $display("FAIL reset_mid_pulses pre=%0d post_offset=%0d expected 2 and 6", pre_pulses, post_off);
        end
        en = 1'b0;
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        int run_left;
        run_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (run_left == 0) begin
                key      = ~key;
                run_left = $urandom_range(1, 30);
            end
            run_left--;
            if ($urandom_range(0, 39) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            checks++;
            if ({up, pressed} !== {exp_up, m_level}) begin
                errors++;
                $display("FAIL random cyc %0d up/pressed=%b%b expected %b%b", cyc, up, pressed, exp_up, m_level);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_auto_repeat();
        test_release_bounce();
        test_reset_mid_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
